// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with frame-based debounce, one key code per accepted press.
// Latency: a press is reported one cycle after the frame that completes debounce (DEBOUNCE_FRAMES frames of 4*SCAN_DIV cycles).
// Backpressure: none; key_valid and key_release are single-cycle pulses. Optional auto-repeat under `define KEYPAD_REPEAT_EN.
module keypad_scan #(
    parameter int SCAN_DIV            = 100000,
    parameter int DEBOUNCE_FRAMES     = 20,
    parameter int REPEAT_DELAY_FRAMES = 500,
    parameter int REPEAT_RATE_FRAMES  = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       key_release
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_FRAMES);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PRESS_DB = 2'd1;
    localparam logic [1:0] S_PRESSED  = 2'd2;
    localparam logic [1:0] S_REL_DB   = 2'd3;

    // Parameter sanity checks at elaboration time.
    if (SCAN_DIV < 4) begin : g_chk_div
        $error("keypad_scan: SCAN_DIV must be >= 4");
    end
    if (DEBOUNCE_FRAMES < 1) begin : g_chk_db
        $error("keypad_scan: DEBOUNCE_FRAMES must be >= 1");
    end
    if (REPEAT_DELAY_FRAMES < 1 || REPEAT_RATE_FRAMES < 1) begin : g_chk_rpt
        $error("keypad_scan: repeat delay and rate must be >= 1");
    end

    logic [3:0]    col_meta;
    logic [3:0]    col_sync;
    logic [DW-1:0] dwell;
    logic [1:0]    row;
    logic [1:0]    acc_hits;   // intersections seen so far this frame: 0, 1, or 2 meaning "two or more"
    logic [3:0]    acc_key;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    cand;

    logic          dwell_last;
    logic          frame_end;
    logic [3:0]    row_hits;
    logic [2:0]    row_pop;
    logic [1:0]    col_idx;
    logic [1:0]    frame_hits;
    logic [3:0]    frame_key;
    logic          single;
    logic          match_cand;
    logic          match_code;
    logic [CW-1:0] cnt_inc;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY_FRAMES + REPEAT_RATE_FRAMES + 1);
    localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY_FRAMES);
    localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_DELAY_FRAMES + REPEAT_RATE_FRAMES);
    logic [RW-1:0] rpt_cnt;
    logic [RW-1:0] rpt_inc;
    assign rpt_inc = rpt_cnt + RW'(1);
`endif

    assign row_n      = ~(4'b0001 << row);
    assign dwell_last = (dwell == DWELL_LAST);
    assign frame_end  = dwell_last && (row == 2'd3);
    assign row_hits   = ~col_sync;
    assign row_pop    = 3'($countones(row_hits));
    assign single     = (frame_hits == 2'd1);
    assign match_cand = single && (frame_key == cand);
    assign match_code = single && (frame_key == key_code);
    assign cnt_inc    = cnt + CW'(1);

    // Two-flop synchronizer; idle (all high) out of reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= col_n;
            col_sync <= col_meta;
        end
    end

    // Fold the current row's columns into the running frame result.
    always_comb begin
        col_idx    = 2'd0;
        frame_hits = acc_hits;
        frame_key  = acc_key;
        for (int c = 0; c < 4; c++) begin
            if (row_hits[c]) col_idx = 2'(c);
        end
        if (row_pop >= 3'd2) begin
            frame_hits = 2'd2;
        end else if (row_pop == 3'd1) begin
            if (acc_hits == 2'd0) begin
                frame_hits = 2'd1;
                frame_key  = {row, col_idx};
            end else begin
                frame_hits = 2'd2;
            end
        end
    end

    // Row dwell timer, row rotation and per-frame accumulation (sampled on the last dwell cycle).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dwell    <= '0;
            row      <= 2'd0;
            acc_hits <= 2'd0;
            acc_key  <= 4'd0;
        end else if (dwell_last) begin
            dwell <= '0;
            row   <= row + 2'd1;
            if (row == 2'd3) begin
                acc_hits <= 2'd0;
                acc_key  <= 4'd0;
            end else begin
                acc_hits <= frame_hits;
                acc_key  <= frame_key;
            end
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    // Press/release debounce FSM, stepped once per completed frame; MULTI and NONE both count as "no key".
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cand        <= 4'd0;
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
            key_release <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt     <= '0;
`endif
        end else begin
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            if (frame_end) begin
                case (state)
                    S_IDLE: begin
                        if (single) begin
                            if (DEBOUNCE_FRAMES == 1) begin
                                key_code  <= frame_key;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= '0;
                                state     <= S_PRESSED;
                            end else begin
                                cand  <= frame_key;
                                cnt   <= CW'(1);
                                state <= S_PRESS_DB;
                            end
                        end
                    end
                    S_PRESS_DB: begin
                        if (match_cand) begin
                            if (cnt_inc == DB_LAST) begin
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= '0;
                                state     <= S_PRESSED;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            cnt   <= '0;
                            state <= S_IDLE;
                        end
                    end
                    S_PRESSED: begin
                        if (match_code) begin
                            cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                            // First repeat after the delay, then fold back so each rate interval pulses again.
                            if (rpt_inc == RPT_NEXT) begin
                                rpt_cnt   <= RPT_FIRST;
                                key_valid <= 1'b1;
                            end else begin
                                rpt_cnt <= rpt_inc;
                                if (rpt_inc == RPT_FIRST) key_valid <= 1'b1;
                            end
`endif
                        end else begin
`ifdef KEYPAD_REPEAT_EN
                            rpt_cnt <= '0;
`endif
                            if (DEBOUNCE_FRAMES == 1) begin
                                key_held    <= 1'b0;
                                key_release <= 1'b1;
                                cnt         <= '0;
                                state       <= S_IDLE;
                            end else begin
                                cnt   <= CW'(1);
                                state <= S_REL_DB;
                            end
                        end
                    end
                    default: begin
                        if (match_code) begin
                            cnt   <= '0;
                            state <= S_PRESSED;
                        end else if (cnt_inc == DB_LAST) begin
                            key_held    <= 1'b0;
                            key_release <= 1'b1;
                            cnt         <= '0;
                            state       <= S_IDLE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad matrix model, vector table, timing corners and a random frame-level reference model.
// Uses SCAN_DIV=4, DEBOUNCE_FRAMES=3 (16-cycle frames); repeat parameters 5/2 apply when KEYPAD_REPEAT_EN is defined.
// Outputs are sampled on the falling edge.
module tb_keypad_scan;
    localparam int SD = 4;
    localparam int DF = 3;
    localparam int RD = 5;
    localparam int RR = 2;
    localparam int FR = 4 * SD;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        key_release;
    logic [15:0] keys;

    int total = 0;
    int bad = 0;
    int k;
    int nv, nr, overlap;

    typedef struct {
        logic [15:0] keys;
        int          nfr;
        int          v;
        int          r;
        int          code;
        int          held;
    } vec_t;
    vec_t tbl[21];

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF),
        .REPEAT_DELAY_FRAMES(RD), .REPEAT_RATE_FRAMES(RR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .col_n(col_n), .row_n(row_n),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
        .key_release(key_release)
    );

    // A pressed key shorts its row to its column; columns pulled up otherwise.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
    end

    // Cycles since reset release: frames end where k is a multiple of FR.
    always @(posedge clk) begin
        if (!reset_n) k <= 0;
        else          k <= k + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (key_valid) nv++;
        if (key_release) nr++;
        if (key_valid && key_release) overlap++;
    endtask

    task automatic frames(input int n);
        repeat (n * FR) tick();
    endtask

    task automatic phase(input int p);
        while (k % FR != p) tick();
    endtask

    // Frame result from the spec rule: the key index if exactly one key is down, else -1.
    function automatic int frame_result(input logic [15:0] ks);
        int res;
        res = -1;
        if ($countones(ks) == 1)
            for (int i = 0; i < 16; i++) if (ks[i]) res = i;
        return res;
    endfunction

    initial begin
        int lat, rlat, hl, cd, expv, sel, a, b, fr;
        int m_held, m_code, run_key, run_len, miss, rpt, ev, rel;

        tbl[0]  = '{16'h0000, 2, 0, 0, 0, 0};
        tbl[1]  = '{16'h0040, 2, 0, 0, 0, 0};
        tbl[2]  = '{16'h0040, 1, 1, 0, 6, 1};
        tbl[3]  = '{16'h0040, 4, 0, 0, 6, 1};
        tbl[4]  = '{16'h0000, 2, 0, 0, 6, 1};
        tbl[5]  = '{16'h0000, 1, 0, 1, 6, 0};
        tbl[6]  = '{16'h0240, 4, 0, 0, 6, 0};
        tbl[7]  = '{16'h0200, 3, 1, 0, 9, 1};
        tbl[8]  = '{16'h0240, 3, 0, 1, 9, 0};
        tbl[9]  = '{16'h0200, 3, 1, 0, 9, 1};
        tbl[10] = '{16'h0040, 3, 0, 1, 9, 0};
        tbl[11] = '{16'h0040, 3, 1, 0, 6, 1};
        tbl[12] = '{16'h0000, 1, 0, 0, 6, 1};
        tbl[13] = '{16'h0040, 1, 0, 0, 6, 1};
        tbl[14] = '{16'h0000, 2, 0, 0, 6, 1};
        tbl[15] = '{16'h0000, 1, 0, 1, 6, 0};
        tbl[16] = '{16'h0040, 2, 0, 0, 6, 0};
        tbl[17] = '{16'h0200, 1, 0, 0, 6, 0};
        tbl[18] = '{16'h0200, 2, 0, 0, 6, 0};
        tbl[19] = '{16'h0200, 1, 1, 0, 9, 1};
        tbl[20] = '{16'h0000, 3, 0, 1, 9, 0};

        keys = 16'h0; reset_n = 1'b0; nv = 0; nr = 0; overlap = 0;
        repeat (3) tick();
        check("reset_row_n", row_n, 4'b1110);
        check("reset_key_code", key_code, 0);
        check("reset_key_valid", key_valid, 0);
        check("reset_key_held", key_held, 0);
        check("reset_key_release", key_release, 0);
        reset_n = 1'b1;

        // Frame-aligned vector table.
        phase(0);
        for (int i = 0; i < 21; i++) begin
            keys = tbl[i].keys; nv = 0; nr = 0;
            frames(tbl[i].nfr);
            check($sformatf("vec%0d_valid", i), nv, tbl[i].v);
            check($sformatf("vec%0d_release", i), nr, tbl[i].r);
            check($sformatf("vec%0d_code", i), key_code, tbl[i].code);
            check($sformatf("vec%0d_held", i), key_held, tbl[i].held);
        end

        // Press/release latency of key (1,2) at an unaligned phase.
        keys = 16'h0; frames(2); phase(12);
        keys = 16'h0040; nv = 0; lat = -1; hl = 0; cd = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (key_valid && lat < 0) begin lat = i; hl = key_held; cd = key_code; end
        end
        check("press_count", nv, 1);
        check_range("press_latency", lat, 48, 64);
        check("press_held_same_cycle", hl, 1);
        check("press_code", cd, 6);
        frames(4); phase(12);
        keys = 16'h0; nr = 0; rlat = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (key_release && rlat < 0) rlat = i;
        end
        check("release_count", nr, 1);
        check_range("release_latency", rlat, 48, 64);
        check("release_held", key_held, 0);
        check("release_code_kept", key_code, 6);

        // Bouncing key (3,3), then a solid hold.
        frames(2); nv = 0;
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? 16'h8000 : 16'h0000;
            repeat (20) tick();
        end
        check("bounce_no_valid", nv, 0);
        keys = 16'h8000; nv = 0;
        repeat (100) tick();
        check("bounce_hold_valid", nv, 1);
        check("bounce_hold_code", key_code, 15);
        keys = 16'h0; frames(6);

        // Two keys from idle, then one of them lifted.
        keys = 16'h0201; nv = 0;
        frames(8);
        check("multi_no_valid", nv, 0);
        keys = 16'h0200; nv = 0;
        repeat (100) tick();
        check("multi_then_single_valid", nv, 1);
        check("multi_then_single_code", key_code, 9);
        keys = 16'h0; frames(6);

        // Long hold of key 4: pulse frames with and without auto-repeat.
        phase(0);
        keys = 16'h0010;
        for (int f = 1; f <= 23; f++) begin
            nv = 0;
            frames(1);
            expv = (f == DF) ? 1 : 0;
`ifdef KEYPAD_REPEAT_EN
            if (f >= DF + RD && (f - DF - RD) % RR == 0) expv = 1;
`endif
            check($sformatf("hold_frame%0d_valid", f), nv, expv);
        end
        keys = 16'h0; frames(6);

        // Random frame-synchronous key patterns against a frame-level model.
        phase(0);
        m_held = 0; m_code = 4; run_key = 0; run_len = 0; miss = 0; rpt = 0;
        for (int f = 0; f < 80; f++) begin
            sel = $urandom_range(0, 99);
            if (sel < 60) begin
                keys = keys;
            end else if (sel < 72) begin
                keys = 16'h0;
            end else if (sel < 92) begin
                keys = 16'h0;
                keys[$urandom_range(0, 15)] = 1'b1;
            end else begin
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                keys = 16'h0; keys[a] = 1'b1; keys[b] = 1'b1;
            end
            nv = 0; nr = 0;
            frames(1);
            fr = frame_result(keys); ev = 0; rel = 0;
            if (m_held == 0) begin
                if (run_len > 0 && fr == run_key) run_len++;
                else if (run_len > 0) run_len = 0;
                else if (fr >= 0) begin run_key = fr; run_len = 1; end
                if (run_len == DF) begin
                    m_held = 1; m_code = run_key; ev = 1; run_len = 0; miss = 0; rpt = 0;
                end
            end else if (fr == m_code) begin
                if (miss > 0) begin
                    miss = 0;
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    rpt++;
                    if (rpt == RD || (rpt > RD && (rpt - RD) % RR == 0)) ev = 1;
`endif
                end
            end else begin
                miss++; rpt = 0;
                if (miss == DF) begin m_held = 0; rel = 1; miss = 0; end
            end
            check($sformatf("rnd%0d_valid", f), nv, ev);
            check($sformatf("rnd%0d_release", f), nr, rel);
            check($sformatf("rnd%0d_held", f), key_held, m_held);
            check($sformatf("rnd%0d_code", f), key_code, m_code);
        end
        keys = 16'h0; frames(6);

        // Reset while key 5 is held and accepted.
        phase(0);
        keys = 16'h0020; nv = 0;
        frames(DF);
        check("pre_reset_valid", nv, 1);
        frames(2);
        reset_n = 1'b0;
        tick();
        check("midreset_row_n", row_n, 4'b1110);
        check("midreset_key_code", key_code, 0);
        check("midreset_key_valid", key_valid, 0);
        check("midreset_key_held", key_held, 0);
        check("midreset_key_release", key_release, 0);
        tick();
        reset_n = 1'b1;
        nv = 0; nr = 0;
        frames(DF);
        check("post_reset_valid", nv, 1);
        check("post_reset_code", key_code, 5);
        check("post_reset_held", key_held, 1);
        check("post_reset_no_release", nr, 0);
        keys = 16'h0; frames(6);

        check("valid_release_overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Input-side counterpart of the multiplexed 8-digit display scanner: scans a 4x4 matrix keypad, debounces it, and reports one key code per press to the clock's setting logic.
- Drives the row lines active-low one at a time and reads the column lines, which are active-low with external pull-ups.
- Sits between the board keypad pins and the time/alarm-setting control FSM.

Parameters:
- SCAN_DIV, 100000: clk cycles each row is driven (1 ms at 100 MHz). Must be >= 4.
- DEBOUNCE_FRAMES, 20: consecutive identical frame results needed to accept a press or a release. Must be >= 1.
- REPEAT_DELAY_FRAMES, 500: frames a key must stay held before auto-repeat starts. Used only with KEYPAD_REPEAT_EN.
- REPEAT_RATE_FRAMES, 100: frames between auto-repeat pulses. Used only with KEYPAD_REPEAT_EN.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: reset, synchronous, active-low; clock clk.
- col_n, input, 4: keypad columns, active-low, asynchronous.
- row_n, output, 4: keypad rows, active-low, one-hot-zero.
- key_code, output, 4: index of the accepted key, row*4+col.
- key_valid, output, 1: one-cycle pulse when key_code is newly valid.
- key_held, output, 1: level, high while the accepted key is held.
- key_release, output, 1: one-cycle pulse when the held key is released.

Behaviour:
- Reset values: row_n=4'b1110, key_code=0, key_valid=0, key_held=0, key_release=0, all counters=0, FSM=IDLE.
- Synchronizer: col_n passes through a 2-flop synchronizer before any use.
- Row scan:
  - Dwell counter runs 0..SCAN_DIV-1; the row index advances 0->1->2->3->0 when dwell wraps.
  - row_n = ~(1<<row) at all times.
- Column sampling:
  - Synchronized columns are sampled on the last dwell cycle of each row, which gives at least 2 cycles of settling.
  - A frame completes when row 3 is sampled.
- Frame result is one of:
  - NONE: no column low in any row.
  - SINGLE(k): exactly one row/column intersection low, k=row*4+col.
  - MULTI: two or more intersections low. MULTI is treated as NONE for press detection; no ghost-key resolution.
- FSM, evaluated once per completed frame:
  - IDLE: SINGLE(k) -> cand=k, cnt=1, go to PRESS_DB. If DEBOUNCE_FRAMES==1, go directly to accept instead.
  - PRESS_DB: SINGLE(cand) -> cnt+1; when cnt reaches DEBOUNCE_FRAMES, accept. Any other result -> IDLE, cnt=0.
  - Accept: key_code<=cand, key_valid=1 for exactly one cycle (the cycle after the frame-end clock edge), key_held<=1, go to PRESSED.
  - PRESSED: SINGLE(key_code) -> stay, cnt=0. Any other result -> REL_DB, cnt=1.
  - REL_DB: SINGLE(key_code) -> back to PRESSED. Any other result -> cnt+1; at DEBOUNCE_FRAMES -> key_held<=0, key_release pulses 1 cycle, go to IDLE.
- Rollover: a second key pressed while the first is held is a MULTI frame, so it leads to release debounce of the first key. The second key is then accepted only through IDLE.
- key_code holds its last accepted value after release.
- Reset mid-press: all outputs return to reset values. A key still held afterwards is re-debounced from IDLE and produces a new key_valid.
- key_valid and key_release never assert in the same cycle.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In PRESSED, a frame counter counts SINGLE(key_code) frames.
  - After REPEAT_DELAY_FRAMES, key_valid pulses once with the same key_code, then again every REPEAT_RATE_FRAMES while the key stays held.
  - The counter clears on leaving PRESSED; REL_DB frames do not count.
- Not defined: exactly one key_valid per accepted press; repeat logic and parameters are unused.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_FRAMES=3 (frame = 16 cycles). The bench models the keypad: col_n[c]=0 while row_n[r]==0 and key (r,c) is pressed.
- Hold key (1,2) from cycle 100 -> exactly one key_valid with key_code=6, at least 48 and at most 64 cycles after the press; key_held=1 from the same cycle.
- Release key (1,2) after 10 frames -> key_release pulses once, 48-64 cycles after release; key_held=0; key_code stays 6.
- Bounce: toggle key (3,3) every 20 cycles for 200 cycles, then hold -> no key_valid during bouncing; one key_valid with key_code=15 after the hold.
- Keys (0,0) and (2,1) held together from idle -> no key_valid. Release (0,0) -> key_valid with key_code=9.
- Assert reset_n=0 for 2 cycles while key 5 is held and accepted -> row_n=4'b1110 and all outputs 0 during reset; a new key_valid with key_code=5 follows about 3 frames later.
- With KEYPAD_REPEAT_EN, REPEAT_DELAY_FRAMES=5, REPEAT_RATE_FRAMES=2, hold key 4 for 20 frames after accept -> key_valid pulses at accept + 5, 7, 9, ... frames. Without the macro -> exactly one pulse.
